peripheral_bb_ram_responder: RTL and testbench
==============================================

Name: peripheral_bb_ram_responder

Overview:
- Memory-side responder for the peripheral black-box RAM port. It receives mclk, rst, addr, din and cen (active-low chip enable) from an initiator and returns dout.
- Adds an active-low write enable (wen), a configurable read-latency pipeline, a read-data-valid strobe, and a post-reset zero-fill sequencer.
- Serves as the synthesizable RAM model behind peripheral initiators and as the reactive end for UVM agents driving the RAM port.

Parameters:
- AW, 8, address width; depth = 2^AW words.
- DW, 16, data width.
- RD_LAT, 1, read latency in cycles from the accepted read to valid dout; legal range 1..4.
- INIT_VAL, 0, DW-bit value written to every word during the init sweep.

Ports:
- mclk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- cen  input  1  chip enable, active-low.
- wen  input  1  write enable, active-low; qualified by cen=0.
- addr  input  AW  word address.
- din  input  DW  write data.
- dout  output  DW  read data; holds its last value between reads.
- dvalid  output  1  one-cycle pulse; dout carries fresh read data.
- rdy  output  1  high once the init sweep is complete and accesses are accepted.

Behaviour:
- Interface decision: one clock, mclk; reset rst is synchronous and active-high.
- Reset values: dout=0, dvalid=0, rdy=0. The read pipeline is flushed and the init pointer is set to 0. The array itself is not reset by rst; it is rewritten by the INIT sweep.
- FSM has two states: INIT and RUN.
  - INIT is entered on any cycle with rst=1.
  - In INIT, each cycle writes mem[ptr]<=INIT_VAL, then ptr<=ptr+1.
  - When ptr=2^AW-1 has been written, go to RUN. The sweep takes exactly 2^AW cycles after rst deasserts, and rdy rises on the following cycle.
- While in INIT:
  - cen, wen, addr and din are ignored.
  - dvalid stays 0 and dout stays 0.
- RUN, write: cen=0 and wen=0 at an edge gives mem[addr]<=din. dout and dvalid are unaffected (no write-through).
- RUN, read: cen=0 and wen=1 at an edge samples mem[addr] into pipeline stage 1.
  - Data propagates through RD_LAT stages.
  - dout is updated and dvalid=1 exactly RD_LAT cycles after the accepting edge.
  - Reads can be issued every cycle, giving one result per cycle with no bubbles.
- RUN, idle: cen=1 means no access; stages with no valid read leave dout unchanged and drive dvalid=0.
- Ordering: one operation per cycle on a single port. A read issued the cycle after a write to the same address returns the new data. A write issued after a read never alters that in-flight read.
- Address wrap: addr is exactly AW bits, so there are no out-of-range accesses. The INIT pointer wraps only once, at the FSM exit.
- Reset mid-operation (rst=1 in RUN or mid-INIT):
  - In-flight reads are discarded with no dvalid.
  - rdy drops on the next edge and the sweep restarts at address 0.
  - Previously written contents are overwritten with INIT_VAL.
- Reset priority: rst=1 wins over any simultaneous cen/wen activity.

Optional Feature:
- Macro: PERIPHERAL_BB_RAM_PARITY_EN.
- When defined:
  - The array stores one extra even-parity bit per word (XOR of the data), computed on writes and during INIT.
  - Adds input perr_inj (1 bit): when high during a write, the stored parity bit is inverted.
  - Adds output perr (1 bit): valid only with dvalid; it is 1 when the recomputed parity of the read word mismatches the stored bit, otherwise 0. Reset value is 0.
- When undefined: no parity storage, and no perr_inj or perr ports.

Test Plan:
- Init sweep (AW=4, RD_LAT=1, INIT_VAL=16'hA5A5): release rst, hold cen=0 and wen=0 with random addr/din. rdy must rise exactly 17 cycles after rst deasserts, and reads of addresses 0..15 must all return 16'hA5A5.
- Write then read (RD_LAT=1): write 16'h1234 to addr 3, read addr 3 on the next cycle. Required: dout=16'h1234 with dvalid=1 one cycle after the read edge.
- Back-to-back pipeline (RD_LAT=3): write 16'h0011, 16'h0022, 16'h0033 to addrs 0..2, then read 0, 1, 2 on consecutive cycles. dvalid must be high for 3 consecutive cycles starting 3 cycles after the first read, with dout=0011, 0022, 0033 in order.
- Idle hold: after a read returns 16'h00FF, hold cen=1 for 5 cycles. dout must stay 16'h00FF with dvalid=0 throughout.
- Reset mid-read (RD_LAT=2): issue a read of addr 5 holding 16'hBEEF, then assert rst on the next cycle. No dvalid pulse is allowed, rdy must be 0 after that edge, and after re-init addr 5 must read INIT_VAL.
- Parity (PERIPHERAL_BB_RAM_PARITY_EN): write 16'h0001 with perr_inj=1 to addr 7 and 16'h0001 with perr_inj=0 to addr 8, then read both. Required: perr=1 with the addr 7 data and perr=0 with the addr 8 data, each aligned with dvalid.

Source files
------------

// File: rtl/peripheral_bb_ram_responder.sv
// Single-port RAM responder with a post-reset INIT_VAL sweep, an RD_LAT-stage read pipeline and a dvalid strobe.
// Optional per-word even parity with error injection is enabled by the PERIPHERAL_BB_RAM_PARITY_EN macro.
module peripheral_bb_ram_responder #(
  parameter int              AW       = 8,
  parameter int              DW       = 16,
  parameter int              RD_LAT   = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          cen,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
  input  logic          perr_inj,
  output logic          perr,
`endif
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          rdy
);

`ifdef PERIPHERAL_BB_RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_q;
  logic [AW-1:0]   ptr_q;
  logic            rdy_q;
  logic [DW-1:0]   dout_q;
  logic            dvalid_q;

  logic [MW-1:0]   mem_q [2**AW];

  logic            mem_we_d;
  logic [AW-1:0]   mem_wa_d;
  logic [MW-1:0]   mem_wd_d;
  logic            rd_en_d;
  logic [MW-1:0]   init_word;
  logic [MW-1:0]   wr_word;

`ifdef PERIPHERAL_BB_RAM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign wr_word   = {(^din) ^ perr_inj, din};
`else
  assign init_word = INIT_VAL;
  assign wr_word   = din;
`endif

  // Accesses are honoured only once rdy is visible; the sweep owns the port before that.
  always_comb begin
    mem_we_d = 1'b0;
    mem_wa_d = addr;
    mem_wd_d = wr_word;
    rd_en_d  = 1'b0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_we_d = 1'b1;
        mem_wa_d = ptr_q;
        mem_wd_d = init_word;
      end else if (rdy_q && !cen) begin
        mem_we_d = !wen;
        rd_en_d  = wen;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) state_q <= ST_RUN;
        end
        ST_RUN:  rdy_q <= 1'b1;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (mem_we_d) mem_q[mem_wa_d] <= mem_wd_d;
  end

  // Stage 0 is the RAM's registered read; later stages only delay data and valid.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic [MW-1:0] dat_q;
      logic          vld_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge mclk) begin
          if (rd_en_d) dat_q <= mem_q[addr];
          vld_q <= rd_en_d;
        end
      end else begin : g_tail
        always_ff @(posedge mclk) begin
          dat_q <= g_stage[gi-1].dat_q;
          vld_q <= !rst && g_stage[gi-1].vld_q;
        end
      end
    end
  endgenerate

  logic [MW-1:0] last_dat;
  logic          last_vld;
  assign last_dat = g_stage[RD_LAT-1].dat_q;
  assign last_vld = g_stage[RD_LAT-1].vld_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= last_vld;
      if (last_vld) dout_q <= last_dat[DW-1:0];
    end
  end

`ifdef PERIPHERAL_BB_RAM_PARITY_EN
  logic perr_q;
  always_ff @(posedge mclk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= last_vld && ((^last_dat[DW-1:0]) != last_dat[DW]);
  end
  assign perr = perr_q;
`endif

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_peripheral_bb_ram_responder.sv
// Directed bench: three responders (RD_LAT 1, 2, 3) share one stimulus; every edge checks dvalid/dout per latency.
module tb_peripheral_bb_ram_responder;

  localparam int          AW = 4;
  localparam int          DW = 16;
  localparam logic [15:0] IV = 16'hA5A5;

  logic          mclk = 1'b0;
  logic          rst;
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout_w   [3];
  logic          dvalid_w [3];
  logic          rdy_w    [3];
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
  logic          perr_inj;
  logic          perr_w   [3];
`endif

  always #5 mclk = ~mclk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      peripheral_bb_ram_responder #(
        .AW(AW), .DW(DW), .RD_LAT(gi + 1), .INIT_VAL(IV)
      ) u_dut (
        .mclk     (mclk),
        .rst      (rst),
        .cen      (cen),
        .wen      (wen),
        .addr     (addr),
        .din      (din),
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
        .perr_inj (perr_inj),
        .perr     (perr_w[gi]),
`endif
        .dout     (dout_w[gi]),
        .dvalid   (dvalid_w[gi]),
        .rdy      (rdy_w[gi])
      );
    end
  endgenerate

  int          errors = 0;
  int          checks = 0;
  int          edge_n = 0;
  logic        acc_vld  [64];
  logic [15:0] acc_dat  [64];
  logic        acc_perr [64];
  logic [15:0] last_d   [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock edge, then compare each latency against the read accepted RD_LAT edges earlier.
  task automatic tick();
    logic rst_edge;
    int   o;
    rst_edge = rst;
    @(posedge mclk);
    #1;
    edge_n++;
    if (rst_edge) begin
      for (int i = 0; i < 64; i++) acc_vld[i] = 1'b0;
      for (int k = 0; k < 3; k++) last_d[k] = 16'h0000;
    end
    for (int k = 0; k < 3; k++) begin
      o = (edge_n - (k + 1)) & 63;
      if (acc_vld[o]) last_d[k] = acc_dat[o];
      check($sformatf("dvalid_L%0d_e%0d", k + 1, edge_n), {31'd0, dvalid_w[k]}, {31'd0, acc_vld[o]});
      check($sformatf("dout_L%0d_e%0d", k + 1, edge_n), {16'd0, dout_w[k]}, {16'd0, last_d[k]});
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
      check($sformatf("perr_L%0d_e%0d", k + 1, edge_n), {31'd0, perr_w[k]},
            {31'd0, acc_vld[o] ? acc_perr[o] : 1'b0});
`endif
    end
    acc_vld[(edge_n + 1) & 63] = 1'b0;
    $display("edge %0d rst=%0b cen=%0b wen=%0b addr=%h dout=%h/%h/%h dvalid=%0b%0b%0b rdy=%0b",
             edge_n, rst_edge, cen, wen, addr, dout_w[0], dout_w[1], dout_w[2],
             dvalid_w[0], dvalid_w[1], dvalid_w[2], rdy_w[0]);
  endtask

  task automatic set_idle();
    cen = 1'b1;
    wen = 1'b1;
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
    perr_inj = 1'b0;
`endif
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d, input logic inj);
    cen  = 1'b0;
    wen  = 1'b0;
    addr = a;
    din  = d;
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
    perr_inj = inj;
`else
    if (inj) $display("note: parity injection requested without parity build");
`endif
    tick();
    set_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [15:0] expv, input logic pexp);
    int slot;
    cen  = 1'b0;
    wen  = 1'b1;
    addr = a;
    slot = (edge_n + 1) & 63;
    acc_vld[slot]  = 1'b1;
    acc_dat[slot]  = expv;
    acc_perr[slot] = pexp;
    tick();
    set_idle();
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_rdy(input logic expv, input string tag);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_L%0d", tag, k + 1), {31'd0, rdy_w[k]}, {31'd0, expv});
  endtask

  // Release reset and count edges until rdy; it must rise on the 17th edge.
  task automatic sweep();
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      cen  = 1'b0;
      wen  = 1'b0;
      addr = AW'($urandom);
      din  = DW'($urandom);
      tick();
      check_rdy(i == 17, $sformatf("rdy_sweep%0d", i));
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      acc_vld[i]  = 1'b0;
      acc_dat[i]  = 16'h0000;
      acc_perr[i] = 1'b0;
    end
    for (int k = 0; k < 3; k++) last_d[k] = 16'h0000;
    rst  = 1'b1;
    cen  = 1'b0;
    wen  = 1'b0;
    addr = '0;
    din  = '0;
`ifdef PERIPHERAL_BB_RAM_PARITY_EN
    perr_inj = 1'b0;
`endif

    tick();
    tick();
    check_rdy(1'b0, "rdy_reset");
    sweep();

    // Every word must hold INIT_VAL; random writes during the sweep were ignored.
    for (int i = 0; i < 16; i++) do_read(AW'(i), IV, 1'b0);
    idle(4);

    do_write(4'd3, 16'h1234, 1'b0);
    do_read(4'd3, 16'h1234, 1'b0);
    idle(4);

    do_write(4'd0, 16'h0011, 1'b0);
    do_write(4'd1, 16'h0022, 1'b0);
    do_write(4'd2, 16'h0033, 1'b0);
    do_read(4'd0, 16'h0011, 1'b0);
    do_read(4'd1, 16'h0022, 1'b0);
    do_read(4'd2, 16'h0033, 1'b0);
    idle(4);

    // A write right behind a read must not disturb the read in flight.
    do_write(4'd9, 16'h00FF, 1'b0);
    do_read(4'd9, 16'h00FF, 1'b0);
    do_write(4'd9, 16'h0000, 1'b0);
    idle(5);
    for (int k = 0; k < 3; k++)
      check($sformatf("idle_hold_L%0d", k + 1), {16'd0, dout_w[k]}, 32'h0000_00FF);
    do_read(4'd9, 16'h0000, 1'b0);
    do_read(4'd15, IV, 1'b0);
    idle(4);

`ifdef PERIPHERAL_BB_RAM_PARITY_EN
    do_write(4'd7, 16'h0001, 1'b1);
    do_write(4'd8, 16'h0001, 1'b0);
    do_read(4'd7, 16'h0001, 1'b1);
    do_read(4'd8, 16'h0001, 1'b0);
    idle(4);
`endif

    // Reset right behind a read: no dvalid may escape and contents are re-initialised.
    do_write(4'd5, 16'hBEEF, 1'b0);
    do_read(4'd5, 16'hBEEF, 1'b0);
    rst = 1'b1;
    tick();
    check_rdy(1'b0, "rdy_midreset");
    sweep();
    do_read(4'd5, IV, 1'b0);
    do_read(4'd3, IV, 1'b0);
    do_read(4'd9, IV, 1'b0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
